// File: rtl/bird_if.sv
// Bird position handshake plus VGA plot stream.
// master = position producer side, slave = renderer.
interface bird_if;
  logic       pos_valid;
  logic [6:0] pos_y;
  logic       pos_ready;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       busy;
  logic       draw_done;

  modport master (
    output pos_valid, pos_y,
    input  pos_ready, plot, x, y, colour, busy, draw_done
  );

  modport slave (
    input  pos_valid, pos_y,
    output pos_ready, plot, x, y, colour, busy, draw_done
  );
endinterface

// File: rtl/bird_renderer.sv
// Erases the old 4x4 bird sprite and draws the new one, one pixel per cycle.
// Optional macro BIRD_EYE_EN: one draw pixel uses EYE_COLOUR.
module bird_renderer #(
  parameter logic [7:0] BIRD_X      = 8'd20,
  parameter logic [6:0] Y_MAX       = 7'd116,
  parameter logic [2:0] BIRD_COLOUR = 3'b010,
  parameter logic [2:0] BG_COLOUR   = 3'b000
`ifdef BIRD_EYE_EN
  , parameter logic [2:0] EYE_COLOUR = 3'b111
`endif
) (
  input  logic clk,
  input  logic reset,
  bird_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    DRAW,
    DONE
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nx;
  logic [6:0] r_old_y;
  logic [6:0] w_old_nx;
  logic [6:0] r_new_y;
  logic [6:0] w_new_nx;
  logic       r_has_drawn;
  logic       w_has_nx;
  logic       r_ready;
  logic       w_accept;
  logic [6:0] w_clamp;
  logic [2:0] w_draw_col;

  logic       w_plot;
  logic [7:0] w_x;
  logic [6:0] w_y;
  logic [2:0] w_col;

  logic       r_plot;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_busy;
  logic       r_done;

  assign w_accept = bus.pos_valid & r_ready;
  assign w_clamp  = (bus.pos_y > Y_MAX) ? Y_MAX : bus.pos_y;

`ifdef BIRD_EYE_EN
  // eye sits at column +3, row +1 of the sprite
  assign w_draw_col = (r_cnt == 4'b1101) ? EYE_COLOUR : BIRD_COLOUR;
`else
  assign w_draw_col = BIRD_COLOUR;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_old_nx   = r_old_y;
    w_new_nx   = r_new_y;
    w_has_nx   = r_has_drawn;
    w_plot     = 1'b0;
    w_x        = r_x;
    w_y        = r_y;
    w_col      = r_colour;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_new_nx = w_clamp;
          w_cnt_nx = 4'd0;
          if (r_has_drawn && (w_clamp != r_old_y))
            w_state_nx = ERASE;
          else
            w_state_nx = DRAW;
        end
      end
      ERASE: begin
        w_plot   = 1'b1;
        w_x      = BIRD_X + {6'd0, r_cnt[3:2]};
        w_y      = r_old_y + {5'd0, r_cnt[1:0]};
        w_col    = BG_COLOUR;
        w_cnt_nx = r_cnt + 4'd1;
        if (r_cnt == 4'd15)
          w_state_nx = DRAW;
      end
      DRAW: begin
        w_plot   = 1'b1;
        w_x      = BIRD_X + {6'd0, r_cnt[3:2]};
        w_y      = r_new_y + {5'd0, r_cnt[1:0]};
        w_col    = w_draw_col;
        w_cnt_nx = r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
          w_old_nx   = r_new_y;
          w_has_nx   = 1'b1;
          w_state_nx = DONE;
        end
      end
      DONE: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_old_y     <= 7'd0;
      r_new_y     <= 7'd0;
      r_has_drawn <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_old_y     <= w_old_nx;
      r_new_y     <= w_new_nx;
      r_has_drawn <= w_has_nx;
    end
  end

  // Plot-side outputs trail the state by one cycle; ready returns after DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_plot   <= 1'b0;
      r_x      <= 8'd0;
      r_y      <= 7'd0;
      r_colour <= 3'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_plot   <= w_plot;
      r_x      <= w_x;
      r_y      <= w_y;
      r_colour <= w_col;
      r_busy   <= w_plot;
      r_done   <= (r_state == DONE);
      r_ready  <= (r_state == IDLE) && !w_accept;
    end
  end

  assign bus.pos_ready = r_ready;
  assign bus.plot      = r_plot;
  assign bus.x         = r_x;
  assign bus.y         = r_y;
  assign bus.colour    = r_colour;
  assign bus.busy      = r_busy;
  assign bus.draw_done = r_done;

endmodule

// File: doc/bird_renderer.md
Name: bird_renderer

Overview:
- Consumer end of the bird position interface.
- Accepts a new bird Y coordinate from the bird motion FSM over a valid/ready handshake.
- Erases the 4x4 sprite at the previously drawn position, then draws it at the new position, as a one-pixel-per-cycle plot stream to the VGA adapter (x, y, colour, plot).
- Sits between the bird control FSM and the VGA adapter's write port.

Parameters:
- BIRD_X, 8'd20: fixed left column of the sprite.
- Y_MAX, 7'd116: largest legal top row; the sprite occupies rows y..y+3 of a 120-row screen.
- BIRD_COLOUR, 3'b010: sprite colour (green).
- BG_COLOUR, 3'b000: erase colour (black).
- EYE_COLOUR, 3'b111: eye pixel colour; used only with BIRD_EYE_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pos_valid  in  1  producer presents pos_y
- pos_y  in  7  requested top row of the sprite
- pos_ready  out  1  renderer can accept a position
- plot  out  1  write enable to the VGA adapter
- x  out  8  pixel column
- y  out  7  pixel row
- colour  out  3  pixel colour
- busy  out  1  high while erasing or drawing
- draw_done  out  1  one-cycle pulse after the last draw pixel

Behaviour:
- Reset values: plot=0, x=0, y=0, colour=0, busy=0, draw_done=0, pos_ready=1, has_drawn=0, old_y=0, pixel counter=0, state=IDLE.
- Asynchronous reset applies immediately, including mid-operation. Any in-flight erase or draw is abandoned. No further plots are issued. has_drawn is cleared, so the next accepted position draws without an erase.
- States: IDLE, ERASE, DRAW, DONE.
- IDLE:
  - pos_ready=1.
  - A transfer occurs on a clk edge with pos_valid=1 and pos_ready=1.
  - The accepted value is clamped: new_y = min(pos_y, Y_MAX), then latched.
  - If has_drawn=1 and new_y != old_y, go to ERASE; otherwise go to DRAW. Equal Y means redraw only.
- ERASE:
  - 16 cycles, pixel counter cnt 0..15.
  - x = BIRD_X + cnt[3:2], y = old_y + cnt[1:0], colour = BG_COLOUR, plot=1.
  - After cnt=15: reset cnt to 0, go to DRAW.
- DRAW:
  - 16 cycles, same addressing as ERASE using new_y, colour = BIRD_COLOUR, plot=1.
  - After cnt=15: old_y <= new_y, has_drawn <= 1, go to DONE.
- DONE:
  - One cycle: draw_done=1, plot=0.
  - Return to IDLE; pos_ready=1 from the following cycle.
- pos_ready=0 in ERASE, DRAW and DONE. pos_valid is ignored there; the producer holds pos_y until accepted.
- busy=1 in ERASE and DRAW.
- All plot-side outputs are registered.
- Latency and cycle counts (handshake edge = cycle 0):
  - First plot at cycle 1.
  - Erase+draw: plots on cycles 1..32, draw_done on cycle 33, pos_ready high at cycle 34.
  - Draw-only: plots on cycles 1..16, draw_done on cycle 17.
- Widths:
  - x arithmetic is 8-bit; BIRD_X+3 must fit within 159 (designer's responsibility).
  - y arithmetic is 7-bit. Clamping guarantees old_y+3 <= 119, so y never wraps.
- plot=0 in IDLE and DONE. x, y and colour hold their last values when plot=0.

Optional Feature:
- Macro: BIRD_EYE_EN.
- Defined: during DRAW, the pixel with cnt=4'b1101 (column BIRD_X+3, row new_y+1) uses EYE_COLOUR. All other DRAW pixels use BIRD_COLOUR. ERASE is unchanged (all BG_COLOUR).
- Undefined: all 16 DRAW pixels use BIRD_COLOUR, and EYE_COLOUR is unused.
- Cycle timing is identical in both builds.

Test Plan:
- Reset, then pos_y=30 with pos_valid=1 for one cycle -> exactly 16 plots, x in 20..23, y in 30..33, colour 3'b010; draw_done pulses on cycle 17; no BG_COLOUR plot.
- After drawing at 30, send pos_y=34 -> 16 plots at y 30..33 with colour 3'b000, then 16 plots at y 34..37 with colour 3'b010; draw_done on cycle 33.
- Send pos_y=127 -> clamped; draw rows 116..119; no y value above 119 ever appears.
- Send pos_y=34 twice in a row -> second transfer gives 16 draw plots only, no erase.
- Hold pos_valid=1 with pos_y changing during busy -> pos_ready=0 throughout; only the value present at the accept edge is rendered; next accept happens in IDLE.
- Assert reset at cycle 10 of an erase, release, send pos_y=50 -> plot drops immediately; the new transfer draws rows 50..53 with no erase. With BIRD_EYE_EN, pixel (23,51) has colour 3'b111.
